// File: rtl/axis_pkg.sv
// Shared AXIS definitions: payload layout, string booleans, clog2.
// Payload packing is {data, keep, user, last} with last at bit 0.
package axis_pkg;

  localparam string AXIS_TRUE  = "true";
  localparam string AXIS_FALSE = "false";

  localparam int AXIS_LAST_BIT = 0;
  localparam int AXIS_USER_LSB = 1;

  function automatic int axis_keep_lsb(input int uw);
    return AXIS_USER_LSB + uw;
  endfunction

  function automatic int axis_data_lsb(input int dw, input int uw);
    return axis_keep_lsb(uw) + dw / 8;
  endfunction

  function automatic int axis_pld_w(input int dw, input int uw);
    return axis_data_lsb(dw, uw) + dw;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_ptr_ctrl.sv
// Pointer, occupancy and handshake control for the AXIS FIFO slice.
// Ready/valid come straight from flops; packet mode adds release logic.
module axis_fifo_ptr_ctrl
  import axis_pkg::*;
#(
  parameter int depth  = 4,
  parameter bit pkt_en = 1'b0,
  localparam int aw = clog2(depth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wr,
  input  logic          rd,
  input  logic          s_last,
  input  logic          m_last,
  output logic [aw-1:0] waddr,
  output logic [aw-1:0] raddr,
  output logic [aw:0]   fill_cnt,
  output logic [aw:0]   pkt_cnt,
  output logic          rdy_q,
  output logic          vld_q,
  output logic          pkt_overrun
);

  localparam logic [aw:0] full_c = (aw+1)'(depth);

  logic [aw:0] wptr;
  logic [aw:0] rptr;
  logic [aw:0] fill_nx;
  logic [aw:0] pkt_nx;
  logic        rel_q;
  logic        rel_nx;
  logic        force_rel;
  logic        vld_nx;
  logic        pkt_in;
  logic        pkt_out;

  assign waddr   = wptr[aw-1:0];
  assign raddr   = rptr[aw-1:0];
  assign pkt_in  = wr && s_last;
  assign pkt_out = rd && m_last;

  always_comb begin
    fill_nx   = fill_cnt;
    pkt_nx    = pkt_cnt;
    rel_nx    = rel_q;
    if (wr && !rd) fill_nx = fill_cnt + 1'b1;
    else if (rd && !wr) fill_nx = fill_cnt - 1'b1;
    if (pkt_in && !pkt_out) pkt_nx = pkt_cnt + 1'b1;
    else if (pkt_out && !pkt_in) pkt_nx = pkt_cnt - 1'b1;
    // full with no complete packet: open the output or it deadlocks
    force_rel = pkt_en && (fill_nx == full_c) && (pkt_nx == '0);
    if (pkt_out) rel_nx = 1'b0;
    if (force_rel) rel_nx = 1'b1;
    vld_nx = (fill_nx != '0) && (!pkt_en || (pkt_nx != '0) || rel_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      fill_cnt    <= '0;
      pkt_cnt     <= '0;
      rdy_q       <= 1'b0;
      vld_q       <= 1'b0;
      rel_q       <= 1'b0;
      pkt_overrun <= 1'b0;
    end else if (en) begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      fill_cnt    <= fill_nx;
      pkt_cnt     <= pkt_nx;
      rdy_q       <= fill_nx < full_c;
      vld_q       <= vld_nx;
      rel_q       <= rel_nx;
      pkt_overrun <= force_rel && !rel_q;
    end
  end

endmodule

// File: rtl/axis_fifo_slice.sv
// Depth-configurable AXIS buffer with optional store-and-forward mode.
// Output payload is a mux over storage flops indexed by the read pointer.
module axis_fifo_slice
  import axis_pkg::*;
#(
  parameter int    data_width       = 32,
  parameter int    user_width       = 1,
  parameter int    depth            = 4,
  parameter string packet_mode      = "false",
  parameter string en_clk_en        = "false",
  parameter int    simulation_delay = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clken,
  input  logic [data_width-1:0]   s_axis_data,
  input  logic [data_width/8-1:0] s_axis_keep,
  input  logic [user_width-1:0]   s_axis_user,
  input  logic                    s_axis_last,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  output logic [data_width-1:0]   m_axis_data,
  output logic [data_width/8-1:0] m_axis_keep,
  output logic [user_width-1:0]   m_axis_user,
  output logic                    m_axis_last,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic [clog2(depth):0]   fill_cnt,
  output logic [clog2(depth):0]   pkt_cnt,
  output logic                    pkt_overrun
);

  localparam int aw = clog2(depth);
  localparam int kw = data_width / 8;
  localparam int pw = axis_pld_w(data_width, user_width);
  localparam int kl = axis_keep_lsb(user_width);
  localparam int dl = axis_data_lsb(data_width, user_width);

  logic          en;
  logic          wr;
  logic          rd;
  logic          rdy_q;
  logic          vld_q;
  logic [aw-1:0] waddr;
  logic [aw-1:0] raddr;
  logic [pw-1:0] pld_in;
  logic [pw-1:0] pld_out;
  logic [pw-1:0] mem [depth];

  if (simulation_delay < 0) begin : g_neg_sim_delay
  end

  assign en           = (en_clk_en == AXIS_FALSE) || clken;
  assign s_axis_ready = rdy_q & en;
  assign m_axis_valid = vld_q & en;
  assign wr           = s_axis_valid & s_axis_ready;
  assign rd           = m_axis_valid & m_axis_ready;

  assign pld_in = {s_axis_data, s_axis_keep, s_axis_user, s_axis_last};

  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= pld_in;
  end

  assign pld_out     = mem[raddr];
  assign m_axis_data = pld_out[dl +: data_width];
  assign m_axis_keep = pld_out[kl +: kw];
  assign m_axis_user = pld_out[AXIS_USER_LSB +: user_width];
  assign m_axis_last = pld_out[AXIS_LAST_BIT];

  axis_fifo_ptr_ctrl #(
    .depth  (depth),
    .pkt_en (packet_mode == AXIS_TRUE)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .wr          (wr),
    .rd          (rd),
    .s_last      (s_axis_last),
    .m_last      (m_axis_last),
    .waddr       (waddr),
    .raddr       (raddr),
    .fill_cnt    (fill_cnt),
    .pkt_cnt     (pkt_cnt),
    .rdy_q       (rdy_q),
    .vld_q       (vld_q),
    .pkt_overrun (pkt_overrun)
  );

endmodule

// File: tb/tb_axis_fifo_slice.sv
// Directed bench for axis_fifo_slice: streaming, backpressure, packet
// mode, forced release, clock enable and mid-packet reset.
module tb_axis_fifo_slice;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: depth 4, stream mode, clock enable on
  logic        a_clken, a_s_last, a_s_valid, a_s_ready;
  logic [31:0] a_s_data, a_m_data;
  logic [3:0]  a_s_keep, a_m_keep;
  logic [0:0]  a_s_user, a_m_user;
  logic        a_m_last, a_m_valid, a_m_ready, a_ovr;
  logic [2:0]  a_fill, a_pkt;

  // b: depth 4 packet mode; c: depth 8 packet mode sharing b's inputs
  logic        b_s_last, b_s_valid, b_s_ready, c_s_valid, c_s_ready;
  logic [31:0] b_s_data, b_m_data, c_m_data;
  logic [3:0]  b_s_keep, b_m_keep, c_m_keep;
  logic [0:0]  b_s_user, b_m_user, c_m_user;
  logic        b_m_last, b_m_valid, b_m_ready, b_ovr;
  logic        c_m_last, c_m_valid, c_ovr;
  logic [2:0]  b_fill, b_pkt;
  logic [3:0]  c_fill, c_pkt;

  int n_cmp;
  int n_err;

  axis_fifo_slice #(
    .depth(4), .packet_mode("false"), .en_clk_en("true")
  ) u_a (
    .clk(clk), .rst_n(rst_n), .clken(a_clken),
    .s_axis_data(a_s_data), .s_axis_keep(a_s_keep),
    .s_axis_user(a_s_user), .s_axis_last(a_s_last),
    .s_axis_valid(a_s_valid), .s_axis_ready(a_s_ready),
    .m_axis_data(a_m_data), .m_axis_keep(a_m_keep),
    .m_axis_user(a_m_user), .m_axis_last(a_m_last),
    .m_axis_valid(a_m_valid), .m_axis_ready(a_m_ready),
    .fill_cnt(a_fill), .pkt_cnt(a_pkt), .pkt_overrun(a_ovr)
  );

  axis_fifo_slice #(
    .depth(4), .packet_mode("true"), .en_clk_en("false")
  ) u_b (
    .clk(clk), .rst_n(rst_n), .clken(1'b0),
    .s_axis_data(b_s_data), .s_axis_keep(b_s_keep),
    .s_axis_user(b_s_user), .s_axis_last(b_s_last),
    .s_axis_valid(b_s_valid), .s_axis_ready(b_s_ready),
    .m_axis_data(b_m_data), .m_axis_keep(b_m_keep),
    .m_axis_user(b_m_user), .m_axis_last(b_m_last),
    .m_axis_valid(b_m_valid), .m_axis_ready(b_m_ready),
    .fill_cnt(b_fill), .pkt_cnt(b_pkt), .pkt_overrun(b_ovr)
  );

  axis_fifo_slice #(
    .depth(8), .packet_mode("true"), .en_clk_en("false")
  ) u_c (
    .clk(clk), .rst_n(rst_n), .clken(1'b0),
    .s_axis_data(b_s_data), .s_axis_keep(b_s_keep),
    .s_axis_user(b_s_user), .s_axis_last(b_s_last),
    .s_axis_valid(c_s_valid), .s_axis_ready(c_s_ready),
    .m_axis_data(c_m_data), .m_axis_keep(c_m_keep),
    .m_axis_user(c_m_user), .m_axis_last(c_m_last),
    .m_axis_valid(c_m_valid), .m_axis_ready(b_m_ready),
    .fill_cnt(c_fill), .pkt_cnt(c_pkt), .pkt_overrun(c_ovr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_clken = 1'b1;
    a_s_data = '0; a_s_keep = '0; a_s_user = '0;
    a_s_last = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
    b_s_data = '0; b_s_keep = '0; b_s_user = '0;
    b_s_last = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0;
    c_s_valid = 1'b0;
    repeat (2) tick();

    chk("rst_a_rdy", 32'(a_s_ready), 0);
    chk("rst_a_vld", 32'(a_m_valid), 0);
    chk("rst_a_fill", 32'(a_fill), 0);
    chk("rst_a_pkt", 32'(a_pkt), 0);
    chk("rst_a_ovr", 32'(a_ovr), 0);
    chk("rst_b_rdy", 32'(b_s_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_a_rdy0", 32'(a_s_ready), 0);
    tick();
    chk("rel_a_rdy1", 32'(a_s_ready), 1);
    chk("rel_b_rdy1", 32'(b_s_ready), 1);
    chk("rel_c_rdy1", 32'(c_s_ready), 1);

    // back-to-back streaming, sink always ready
    a_m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_s_data = 32'(i);
      a_s_keep = 4'(i);
      a_s_user = 1'(i >> 1);
      a_s_last = 1'(i);
      a_s_valid = 1'b1;
      #1;
      chk("str_rdy", 32'(a_s_ready), 1);
      if (i == 1) chk("str_vld_pre", 32'(a_m_valid), 0);
      tick();
      chk("str_vld", 32'(a_m_valid), 1);
      chk("str_data", a_m_data, 32'(i));
      chk("str_keep", 32'(a_m_keep), 32'(i & 15));
      chk("str_user", 32'(a_m_user), 32'((i >> 1) & 1));
      chk("str_last", 32'(a_m_last), 32'(i & 1));
      chk("str_fill", 32'(a_fill), 1);
    end
    a_s_valid = 1'b0;
    tick();
    chk("str_end_vld", 32'(a_m_valid), 0);
    chk("str_end_fill", 32'(a_fill), 0);

    // backpressure to full, then drain
    a_m_ready = 1'b0;
    a_s_keep = 4'hf; a_s_user = '0; a_s_last = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      a_s_data = 32'h20 + 32'(j);
      a_s_valid = 1'b1;
      tick();
      chk("bp_fill", 32'(a_fill), 32'(j));
    end
    chk("bp_full_rdy", 32'(a_s_ready), 0);
    chk("bp_full_vld", 32'(a_m_valid), 1);
    chk("bp_head", a_m_data, 32'h21);
    a_s_data = 32'h25;
    tick();
    chk("bp_hold_fill", 32'(a_fill), 4);
    chk("bp_hold_rdy", 32'(a_s_ready), 0);
    a_m_ready = 1'b1;
    tick();
    chk("bp_d22", a_m_data, 32'h22);
    chk("bp_f3", 32'(a_fill), 3);
    chk("bp_rdy_back", 32'(a_s_ready), 1);
    tick();
    chk("bp_d23", a_m_data, 32'h23);
    a_s_data = 32'h26;
    tick();
    chk("bp_d24", a_m_data, 32'h24);
    chk("bp_f3b", 32'(a_fill), 3);
    a_s_valid = 1'b0;
    tick();
    chk("bp_d25", a_m_data, 32'h25);
    chk("bp_f2", 32'(a_fill), 2);
    tick();
    chk("bp_d26", a_m_data, 32'h26);
    tick();
    chk("bp_empty", 32'(a_m_valid), 0);
    chk("bp_f0", 32'(a_fill), 0);

    // clock enable toggling during streaming
    for (int k = 1; k <= 4; k++) begin
      a_clken = 1'b1;
      a_s_data = 32'h30 + 32'(k);
      a_s_valid = 1'b1;
      #1;
      chk("ce_rdy_on", 32'(a_s_ready), 1);
      tick();
      a_clken = 1'b0;
      #1;
      chk("ce_rdy_off", 32'(a_s_ready), 0);
      chk("ce_vld_off", 32'(a_m_valid), 0);
      tick();
      chk("ce_fill_hold", 32'(a_fill), 1);
      a_clken = 1'b1;
      #1;
      chk("ce_vld_on", 32'(a_m_valid), 1);
      chk("ce_data", a_m_data, 32'h30 + 32'(k));
    end
    a_s_valid = 1'b0;
    tick();
    chk("ce_end_fill", 32'(a_fill), 0);

    // store-and-forward: 3-beat packet
    b_m_ready = 1'b1;
    b_s_keep = 4'hf;
    b_s_valid = 1'b1;
    c_s_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      b_s_data = 32'h40 + 32'(k);
      b_s_last = (k == 3);
      tick();
      if (k < 3) begin
        chk("pk_b_hold", 32'(b_m_valid), 0);
        chk("pk_c_hold", 32'(c_m_valid), 0);
        chk("pk_b_fill", 32'(b_fill), 32'(k));
      end
    end
    chk("pk_b_vld", 32'(b_m_valid), 1);
    chk("pk_c_vld", 32'(c_m_valid), 1);
    chk("pk_b_pkt", 32'(b_pkt), 1);
    chk("pk_c_pkt", 32'(c_pkt), 1);
    chk("pk_b_d41", b_m_data, 32'h41);
    b_s_valid = 1'b0;
    c_s_valid = 1'b0;
    b_s_last = 1'b0;
    tick();
    chk("pk_b_d42", b_m_data, 32'h42);
    chk("pk_c_d42", c_m_data, 32'h42);
    tick();
    chk("pk_b_d43", b_m_data, 32'h43);
    chk("pk_b_last", 32'(b_m_last), 1);
    tick();
    chk("pk_b_done_vld", 32'(b_m_valid), 0);
    chk("pk_b_done_pkt", 32'(b_pkt), 0);
    chk("pk_c_done_pkt", 32'(c_pkt), 0);

    // 6-beat packet on depth 4: forced release
    b_s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      b_s_data = 32'h50 + 32'(k);
      tick();
      if (k < 4) begin
        chk("ov_pre_vld", 32'(b_m_valid), 0);
        chk("ov_pre_ovr", 32'(b_ovr), 0);
      end
    end
    chk("ov_pulse", 32'(b_ovr), 1);
    chk("ov_vld", 32'(b_m_valid), 1);
    chk("ov_rdy", 32'(b_s_ready), 0);
    chk("ov_fill4", 32'(b_fill), 4);
    chk("ov_d51", b_m_data, 32'h51);
    b_s_data = 32'h55;
    tick();
    chk("ov_pulse_end", 32'(b_ovr), 0);
    chk("ov_d52", b_m_data, 32'h52);
    chk("ov_rdy_back", 32'(b_s_ready), 1);
    tick();
    chk("ov_d53", b_m_data, 32'h53);
    b_s_data = 32'h56;
    b_s_last = 1'b1;
    tick();
    chk("ov_d54", b_m_data, 32'h54);
    chk("ov_pkt1", 32'(b_pkt), 1);
    b_s_valid = 1'b0;
    b_s_last = 1'b0;
    tick();
    chk("ov_d55", b_m_data, 32'h55);
    chk("ov_f2", 32'(b_fill), 2);
    tick();
    chk("ov_d56", b_m_data, 32'h56);
    chk("ov_last", 32'(b_m_last), 1);
    tick();
    chk("ov_done_vld", 32'(b_m_valid), 0);
    chk("ov_done_pkt", 32'(b_pkt), 0);
    chk("ov_c_quiet", 32'(c_ovr), 0);

    // release must be cleared: partial packet waits again
    b_s_data = 32'h61;
    b_s_valid = 1'b1;
    tick();
    b_s_valid = 1'b0;
    chk("rc_hold_vld", 32'(b_m_valid), 0);
    tick();
    chk("rc_hold_vld2", 32'(b_m_valid), 0);
    chk("rc_hold_fill", 32'(b_fill), 1);
    b_s_data = 32'h62;
    b_s_last = 1'b1;
    b_s_valid = 1'b1;
    tick();
    b_s_valid = 1'b0;
    b_s_last = 1'b0;
    chk("rc_vld", 32'(b_m_valid), 1);
    chk("rc_d61", b_m_data, 32'h61);
    tick();
    chk("rc_d62", b_m_data, 32'h62);
    tick();
    chk("rc_empty", 32'(b_fill), 0);

    // reset in the middle of traffic
    a_m_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      a_s_data = 32'h90 + 32'(k);
      b_s_data = 32'h70 + 32'(k);
      a_s_valid = 1'b1;
      b_s_valid = 1'b1;
      tick();
    end
    a_s_valid = 1'b0;
    b_s_valid = 1'b0;
    chk("mr_a_fill3", 32'(a_fill), 3);
    chk("mr_b_fill3", 32'(b_fill), 3);
    chk("mr_a_vld", 32'(a_m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_a_vld0", 32'(a_m_valid), 0);
    chk("mr_a_fill0", 32'(a_fill), 0);
    chk("mr_b_fill0", 32'(b_fill), 0);
    chk("mr_b_pkt0", 32'(b_pkt), 0);
    chk("mr_a_rdy0", 32'(a_s_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_b_rdy_low", 32'(b_s_ready), 0);
    tick();
    chk("mr_b_rdy", 32'(b_s_ready), 1);
    b_s_data = 32'h81;
    b_s_last = 1'b1;
    b_s_valid = 1'b1;
    a_s_data = 32'hA1;
    a_s_valid = 1'b1;
    tick();
    b_s_valid = 1'b0;
    b_s_last = 1'b0;
    a_s_valid = 1'b0;
    chk("mr_b_vld", 32'(b_m_valid), 1);
    chk("mr_b_d81", b_m_data, 32'h81);
    chk("mr_b_pkt1", 32'(b_pkt), 1);
    chk("mr_a_dA1", a_m_data, 32'hA1);
    chk("mr_a_fill1", 32'(a_fill), 1);
    a_m_ready = 1'b1;
    tick();
    chk("mr_a_drain", 32'(a_m_valid), 0);
    chk("mr_b_drain", 32'(b_m_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
